// File: rtl/vALU_pkg.sv
// Shared vALU definitions: reduction sequencer states, SEW encodings and
// the per-lane identity values for min/max reductions.
package vALU_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FOLD  = 2'd2,
        SEED  = 2'd3
    } state_e;

    localparam logic [1:0] SEW_E8  = 2'd0;
    localparam logic [1:0] SEW_E16 = 2'd1;
    localparam logic [1:0] SEW_E32 = 2'd2;
    localparam logic [1:0] SEW_E64 = 2'd3;

    // Identity replicated into every SEW lane of a 64-bit word. Unsigned
    // identities are all-zeros (max) or all-ones (min); signed ones flip the
    // lane sign bit of those.
    function automatic logic [63:0] identity_word(input logic [1:0] sew,
                                                  input logic       op_max,
                                                  input logic       op_signed);
        logic [63:0] base_s;
        logic [63:0] sign_mask_s;
        if (op_max) begin
            base_s = 64'h0000_0000_0000_0000;
        end else begin
            base_s = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        case (sew)
            SEW_E8:  sign_mask_s = 64'h8080_8080_8080_8080;
            SEW_E16: sign_mask_s = 64'h8000_8000_8000_8000;
            SEW_E32: sign_mask_s = 64'h8000_0000_8000_0000;
            SEW_E64: sign_mask_s = 64'h8000_0000_0000_0000;
            default: sign_mask_s = 64'h8000_0000_8000_0000;
        endcase
        if (op_signed) begin
            identity_word = base_s ^ sign_mask_s;
        end else begin
            identity_word = base_s;
        end
    endfunction

endpackage

// File: rtl/vlane_better.sv
// Combinational compare-and-select of one W-bit element pair: returns the
// "better" of a and b for min/max under signed or unsigned ordering.
module vlane_better #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_max,
    input  logic         op_signed,
    output logic [W-1:0] y
);

    logic [W-1:0] lhs_s;
    logic [W-1:0] rhs_s;
    logic [W+1:0] diff_s;

    // b wins only when strictly better, so ties keep a (the accumulator side).
    always_comb begin
        if (op_max) begin
            lhs_s = a;
            rhs_s = b;
        end else begin
            lhs_s = b;
            rhs_s = a;
        end
        diff_s = {op_signed & lhs_s[W-1], lhs_s, 1'b0}
               - {op_signed & rhs_s[W-1], rhs_s, 1'b0};
        if (diff_s[W+1]) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/vminmax_reduce_ctrl.sv
// Sequencer for vredmin/vredminu/vredmax/vredmaxu: accumulates vs2 beats
// lane-wise, folds the accumulator down to one element, then applies vs1[0].
module vminmax_reduce_ctrl
    import vALU_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int SEW_WIDTH      = 2,
    parameter int REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8,
    parameter bit ENABLE_64_BIT  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SEW_WIDTH-1:0]      sew,
    input  logic                      op_max,
    input  logic                      op_signed,
    input  logic [63:0]               seed,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REQ_DATA_WIDTH-1:0] in_data,
    input  logic [REQ_BE_WIDTH-1:0]   in_be,
    input  logic                      in_last,
    output logic                      busy,
    output logic                      out_valid,
    output logic [63:0]               out_data
);

    localparam int         DW      = REQ_DATA_WIDTH;
    localparam int         NB      = REQ_BE_WIDTH;
    localparam logic [6:0] DW_BITS = 7'(REQ_DATA_WIDTH);
    // 64-bit elements need both the feature and a 64-bit beat.
    localparam logic [1:0] MAX_SEW = (REQ_DATA_WIDTH == 64 && ENABLE_64_BIT) ? SEW_E64 : SEW_E32;

    state_e          state_r;
    state_e          next_state_s;
    logic [1:0]      sew_r;
    logic            op_max_r;
    logic            op_signed_r;
    logic [63:0]     seed_r;
    logic [DW-1:0]   acc_r;
    logic [6:0]      active_r;
    logic            in_ready_r;
    logic            busy_r;
    logic            out_valid_r;
    logic [63:0]     out_data_r;

    logic [1:0]      eff_sew_s;
    logic [63:0]     start_ident_s;
    logic [6:0]      sew_bits_s;
    logic [6:0]      half_s;
    logic [DW-1:0]   b_s;
    logic [NB-1:0]   en_s;
    logic [DW-1:0]   y8_s;
    logic [DW-1:0]   y16_s;
    logic [DW-1:0]   y32_s;
    logic [DW-1:0]   y64_s;
    logic [DW-1:0]   bank_s;
    logic [63:0]     lane0_mask_s;
    logic [63:0]     result_s;

    assign eff_sew_s     = (sew[1:0] > MAX_SEW) ? MAX_SEW : sew[1:0];
    assign start_ident_s = identity_word(eff_sew_s, op_max, op_signed);
    assign sew_bits_s    = 7'd8 << sew_r;
    assign half_s        = active_r >> 1;

    // Compare-bank operand and lane-enable selection per phase.
    always_comb begin
        b_s  = acc_r;
        en_s = {NB{1'b1}};
        case (state_r)
            ACCUM: begin
                b_s  = in_data;
                en_s = in_be;
            end
            FOLD:    b_s = acc_r >> half_s;
            SEED:    b_s = seed_r[DW-1:0];
            IDLE:    b_s = acc_r;
            default: b_s = acc_r;
        endcase
    end

    // One compare bank per element width; the latched sew picks the bank.
    for (genvar i = 0; i < NB; i++) begin : g_b8
        vlane_better #(.W(8)) u_better (
            .a(acc_r[8*i +: 8]), .b(b_s[8*i +: 8]),
            .op_max(op_max_r), .op_signed(op_signed_r), .y(y8_s[8*i +: 8])
        );
    end
    for (genvar i = 0; i < NB / 2; i++) begin : g_b16
        vlane_better #(.W(16)) u_better (
            .a(acc_r[16*i +: 16]), .b(b_s[16*i +: 16]),
            .op_max(op_max_r), .op_signed(op_signed_r), .y(y16_s[16*i +: 16])
        );
    end
    for (genvar i = 0; i < NB / 4; i++) begin : g_b32
        vlane_better #(.W(32)) u_better (
            .a(acc_r[32*i +: 32]), .b(b_s[32*i +: 32]),
            .op_max(op_max_r), .op_signed(op_signed_r), .y(y32_s[32*i +: 32])
        );
    end
    if (DW == 64) begin : g_b64
        vlane_better #(.W(64)) u_better (
            .a(acc_r), .b(b_s),
            .op_max(op_max_r), .op_signed(op_signed_r), .y(y64_s)
        );
    end else begin : g_no_b64
        assign y64_s = acc_r;
    end

    // Per-element merge: masked elements keep the accumulator value.
    always_comb begin
        bank_s = acc_r;
        case (sew_r)
            SEW_E8: begin
                for (int i = 0; i < NB; i++) begin
                    bank_s[8*i +: 8] = en_s[i] ? y8_s[8*i +: 8] : acc_r[8*i +: 8];
                end
            end
            SEW_E16: begin
                for (int i = 0; i < NB / 2; i++) begin
                    bank_s[16*i +: 16] = en_s[2*i] ? y16_s[16*i +: 16] : acc_r[16*i +: 16];
                end
            end
            SEW_E32: begin
                for (int i = 0; i < NB / 4; i++) begin
                    bank_s[32*i +: 32] = en_s[4*i] ? y32_s[32*i +: 32] : acc_r[32*i +: 32];
                end
            end
            SEW_E64: bank_s = en_s[0] ? y64_s : acc_r;
            default: bank_s = acc_r;
        endcase
    end

    // Lane 0 of the bank, zero-extended from the element width.
    always_comb begin
        case (sew_r)
            SEW_E8:  lane0_mask_s = 64'h0000_0000_0000_00FF;
            SEW_E16: lane0_mask_s = 64'h0000_0000_0000_FFFF;
            SEW_E32: lane0_mask_s = 64'h0000_0000_FFFF_FFFF;
            SEW_E64: lane0_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            default: lane0_mask_s = 64'h0000_0000_FFFF_FFFF;
        endcase
        result_s           = 64'd0;
        result_s[DW-1:0]   = bank_s & lane0_mask_s[DW-1:0];
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = ACCUM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_r && in_last) begin
                    next_state_s = (DW_BITS == sew_bits_s) ? SEED : FOLD;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            FOLD: begin
                if (half_s == sew_bits_s) begin
                    next_state_s = SEED;
                end else begin
                    next_state_s = FOLD;
                end
            end
            SEED:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, configuration, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sew_r       <= SEW_E8;
            op_max_r    <= 1'b0;
            op_signed_r <= 1'b0;
            seed_r      <= 64'd0;
            acc_r       <= {DW{1'b1}};  // min-unsigned identity of the reset config
            active_r    <= DW_BITS;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 64'd0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ACCUM);
            busy_r      <= (next_state_s != IDLE);
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sew_r       <= eff_sew_s;
                        op_max_r    <= op_max;
                        op_signed_r <= op_signed;
                        seed_r      <= seed;
                        acc_r       <= start_ident_s[DW-1:0];
                        active_r    <= DW_BITS;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready_r) begin
                        acc_r <= bank_s;
                    end
                end
                FOLD: begin
                    acc_r    <= bank_s;
                    active_r <= half_s;
                end
                SEED: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= result_s;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
